// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - single-outstanding data-bus to SRAM bridge with wait states
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   data_req_i / data_gnt_o   core request / combinational grant (IDLE only)
//   data_addr_i, data_we_i,   request fields, captured on grant
//   data_be_i, data_wdata_i
//   data_rvalid_o             one-cycle response strobe
//   data_rdata_o, data_err_o  response data / out-of-window error
//   mem_cs_o, mem_we_o,       SRAM strobes, asserted only in ACCESS
//   mem_be_o, mem_addr_o,     SRAM byte enables, word address, write data
//   mem_wdata_o
//   mem_rdata_i               SRAM read data, valid the cycle after a read select
module data_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          ADDR_WIDTH  = 14,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic [31:0]           data_rdata_o,
  output logic                  data_err_o,
  output logic                  mem_cs_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  // Counter reload value: WAIT then runs for exactly WAIT_CYCLES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:2] addr_q, addr_d;   // byte offset bits are never used
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        in_win;

  // Byte lanes come from be alone, so the low address bits are dropped.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^data_addr_i[1:0];

  assign in_win = (addr_q[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    we_d          = we_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    // Gated by reset so every output reads 0 while rst_i is high.
    data_gnt_o    = data_req_i && (state_q == IDLE) && !rst_i;
    data_rvalid_o = 1'b0;
    data_err_o    = 1'b0;
    data_rdata_o  = 32'd0;
    mem_cs_o      = 1'b0;
    mem_we_o      = 1'b0;
    // Captured fields drive the SRAM bus directly; only cs/we qualify them.
    mem_be_o      = be_q;
    mem_addr_o    = addr_q[ADDR_WIDTH+1:2];
    mem_wdata_o   = wdata_q;

    case (state_q)
      IDLE: begin
        if (data_gnt_o) begin
          addr_d  = data_addr_i[31:2];
          we_d    = data_we_i;
          be_d    = data_be_i;
          wdata_d = data_wdata_i;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACCESS: begin
        // Out-of-window accesses keep the SRAM untouched but still take the slot.
        mem_cs_o = in_win;
        mem_we_o = in_win && we_q;
        state_d  = RESP;
      end
      RESP: begin
        data_rvalid_o = 1'b1;
        data_err_o    = !in_win;
        data_rdata_o  = (in_win && !we_q) ? mem_rdata_i : 32'd0;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
